// File: rtl/game_flow_ctrl_pkg.sv
// Shared game state codes and digit helpers for the game sequencer and the pixel generator.
package game_pkg;

  localparam int STATE_W = 3;
  localparam int DIGIT_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_RST    = 3'd0,
    ST_B_RST  = 3'd1,
    ST_B_PLAY = 3'd2,
    ST_PLAY   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // BCD score increment that sticks at 9.
  function automatic logic [DIGIT_W-1:0] sat_inc(input logic [DIGIT_W-1:0] d);
    return (d >= DIGIT_W'(9)) ? DIGIT_W'(9) : d + DIGIT_W'(1);
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Button/point/vsync inputs and display/run outputs of the game sequencer.
interface game_flow_ctrl_if;
  import game_pkg::*;

  logic                start;
  logic                abort;
  logic                point0;
  logic                point1;
  logic                vsync;
  logic [STATE_W-1:0]  state;
  logic [DIGIT_W-1:0]  score0;
  logic [DIGIT_W-1:0]  score1;
  logic [DIGIT_W-1:0]  cnt0;
  logic                ball_en;
  logic                serve_dir;
  logic                winner;

  modport master (
    output start, abort, point0, point1, vsync,
    input  state, score0, score1, cnt0, ball_en, serve_dir, winner
  );

  modport slave (
    input  start, abort, point0, point1, vsync,
    output state, score0, score1, cnt0, ball_en, serve_dir, winner
  );

endinterface

// File: rtl/game_flow_ctrl_sec_tick_gen.sv
// Free-running step counter: one-cycle tick every TICK_CYCLES enabled cycles; clr wins over en.
module sec_tick_gen #(
  parameter int TICK_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: serve countdown, score counters and win detection.
// Optional FRAME_SYNC_EN: display outputs held in shadows reloaded once per frame after vsync falls.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int TICK_CYCLES = 25_000_000,
  parameter int CNT_START   = 3,
  parameter int WIN_SCORE   = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  game_flow_ctrl_if.slave bus
);

  localparam logic [DIGIT_W-1:0] WIN_D = DIGIT_W'(WIN_SCORE);
  localparam logic [DIGIT_W-1:0] CNT_D = DIGIT_W'(CNT_START);

  state_t               state_q, state_d;
  logic [DIGIT_W-1:0]   score0_q, score0_d, score1_q, score1_d, cnt0_q, cnt0_d;
  logic                 serve_dir_q, serve_dir_d, winner_q, winner_d, ball_en_q, ball_en_d;
  logic                 tick;
  logic [DIGIT_W-1:0]   s0_inc, s1_inc;

  // The step counter only runs in B_PLAY, so it is always fresh on entry.
  sec_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != ST_B_PLAY),
    .en    (state_q == ST_B_PLAY),
    .tick  (tick)
  );

  assign s0_inc = sat_inc(score0_q);
  assign s1_inc = sat_inc(score1_q);

  always_comb begin
    state_d     = state_q;
    score0_d    = score0_q;
    score1_d    = score1_q;
    serve_dir_d = serve_dir_q;
    if (bus.abort) begin
      state_d = ST_RST;
    end else begin
      case (state_q)
        ST_RST: begin
          score0_d    = '0;
          score1_d    = '0;
          serve_dir_d = 1'b0;
          state_d     = ST_B_RST;
        end
        ST_B_RST:  if (bus.start) state_d = ST_B_PLAY;
        ST_B_PLAY: if (tick && cnt0_q <= DIGIT_W'(1)) state_d = ST_PLAY;
        ST_PLAY: begin
          if (bus.point0 || bus.point1) begin
            if (bus.point0) score0_d = s0_inc;
            if (bus.point1) score1_d = s1_inc;
            // Serve goes toward whoever conceded; a double point keeps the direction.
            if (bus.point0 && !bus.point1) serve_dir_d = 1'b1;
            if (bus.point1 && !bus.point0) serve_dir_d = 1'b0;
            state_d = (score0_d == WIN_D || score1_d == WIN_D) ? ST_FINISH : ST_B_PLAY;
          end
        end
        ST_FINISH: if (bus.start) state_d = ST_RST;
        default:   state_d = ST_RST;
      endcase
    end

    cnt0_d = '0;
    if (state_d == ST_B_PLAY) begin
      if (state_q != ST_B_PLAY) cnt0_d = CNT_D;
      else if (tick)            cnt0_d = cnt0_q - DIGIT_W'(1);
      else                      cnt0_d = cnt0_q;
    end

    ball_en_d = (state_d == ST_PLAY);
    winner_d  = (state_d == ST_FINISH) && (score1_d >= WIN_D) && (score0_d < WIN_D);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      score0_q    <= '0;
      score1_q    <= '0;
      cnt0_q      <= '0;
      serve_dir_q <= 1'b0;
      winner_q    <= 1'b0;
      ball_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      score0_q    <= score0_d;
      score1_q    <= score1_d;
      cnt0_q      <= cnt0_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      ball_en_q   <= ball_en_d;
    end
  end

`ifdef FRAME_SYNC_EN
  logic                vsync_q, load_q;
  logic [STATE_W-1:0]  state_sh_q;
  logic [DIGIT_W-1:0]  score0_sh_q, score1_sh_q, cnt0_sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b1;
      load_q      <= 1'b0;
      state_sh_q  <= ST_RST;
      score0_sh_q <= '0;
      score1_sh_q <= '0;
      cnt0_sh_q   <= '0;
    end else begin
      vsync_q <= bus.vsync;
      load_q  <= vsync_q && !bus.vsync;
      if (load_q) begin
        state_sh_q  <= state_q;
        score0_sh_q <= score0_q;
        score1_sh_q <= score1_q;
        cnt0_sh_q   <= cnt0_q;
      end
    end
  end

  assign bus.state  = state_sh_q;
  assign bus.score0 = score0_sh_q;
  assign bus.score1 = score1_sh_q;
  assign bus.cnt0   = cnt0_sh_q;
`else
  assign bus.state  = state_q;
  assign bus.score0 = score0_q;
  assign bus.score1 = score1_q;
  assign bus.cnt0   = cnt0_q;
`endif

  assign bus.ball_en   = ball_en_q;
  assign bus.serve_dir = serve_dir_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios plus a randomized run against a rule-level model.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam int TICK = 4;
  localparam int CNT  = 3;
  localparam int WIN  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_flow_ctrl_if bus ();

  game_flow_ctrl #(.TICK_CYCLES(TICK), .CNT_START(CNT), .WIN_SCORE(WIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int frame_ctr = 0;

  // Rule-level model: countdown tracked as cycles remaining in the serve phase.
  int m_state, m_s0, m_s1, m_remain, m_dir;
  int d_state, d_s0, d_s1, d_cnt;
  bit m_vs_prev, m_load;

  function automatic int m_cnt0();
    return (m_state == 2) ? (m_remain + TICK - 1) / TICK : 0;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_s0 = 0; m_s1 = 0; m_remain = 0; m_dir = 0;
    d_state = 0; d_s0 = 0; d_s1 = 0; d_cnt = 0;
    m_vs_prev = 1'b1; m_load = 1'b0;
  endfunction

  function automatic void model_step(bit st, bit ab, bit p0, bit p1, bit vs);
    int ps, ps0, ps1, pc;
    ps = m_state; ps0 = m_s0; ps1 = m_s1; pc = m_cnt0();
    if (ab) m_state = 0;
    else begin
      case (m_state)
        0: begin m_s0 = 0; m_s1 = 0; m_dir = 0; m_state = 1; end
        1: if (st) begin m_state = 2; m_remain = CNT * TICK; end
        2: begin m_remain--; if (m_remain == 0) m_state = 3; end
        3: if (p0 || p1) begin
             if (p0) m_s0 = (m_s0 < 9) ? m_s0 + 1 : 9;
             if (p1) m_s1 = (m_s1 < 9) ? m_s1 + 1 : 9;
             if (p0 && !p1) m_dir = 1;
             if (p1 && !p0) m_dir = 0;
             if (m_s0 == WIN || m_s1 == WIN) m_state = 4;
             else begin m_state = 2; m_remain = CNT * TICK; end
           end
        4: if (st) m_state = 0;
        default: m_state = 0;
      endcase
    end
`ifdef FRAME_SYNC_EN
    if (m_load) begin d_state = ps; d_s0 = ps0; d_s1 = ps1; d_cnt = pc; end
    m_load = m_vs_prev && !vs;
    m_vs_prev = vs;
`else
    d_state = m_state; d_s0 = m_s0; d_s1 = m_s1; d_cnt = m_cnt0();
`endif
  endfunction

  function automatic bit m_winner();
    return (m_state == 4) && (m_s1 >= WIN) && (m_s0 < WIN);
  endfunction

  task automatic cyc(input bit st, input bit ab, input bit p0, input bit p1);
    @(negedge clk);
    bus.start = st; bus.abort = ab; bus.point0 = p0; bus.point1 = p1;
    frame_ctr++;
    bus.vsync = (frame_ctr % 16) >= 2;
    @(posedge clk);
    model_step(st, ab, p0, p1, bus.vsync);
    #1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.point0 = 1'b0; bus.point1 = 1'b0;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    bus.start = 0; bus.abort = 0; bus.point0 = 0; bus.point1 = 0; bus.vsync = 1;
    rst_n = 1'b0;
    model_reset();
    #12;
    n_checks++; if (bus.state !== 3'd0)  begin n_fail++; $display("FAIL reset_state got %0d exp 0", bus.state); end
    n_checks++; if (bus.score0 !== 4'd0) begin n_fail++; $display("FAIL reset_score0 got %0d exp 0", bus.score0); end
    n_checks++; if (bus.score1 !== 4'd0) begin n_fail++; $display("FAIL reset_score1 got %0d exp 0", bus.score1); end
    n_checks++; if (bus.cnt0 !== 4'd0)   begin n_fail++; $display("FAIL reset_cnt0 got %0d exp 0", bus.cnt0); end
    n_checks++; if ({bus.ball_en, bus.serve_dir, bus.winner} !== 3'b000)
      begin n_fail++; $display("FAIL reset_flags got %b exp 000", {bus.ball_en, bus.serve_dir, bus.winner}); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    n_checks++; if (bus.state !== 3'(d_state)) begin n_fail++; $display("FAIL reset_to_brst got %0d exp %0d", bus.state, d_state); end
`ifndef FRAME_SYNC_EN
    n_checks++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL reset_brst_const got %0d exp 1", bus.state); end
`endif
  endtask

  task automatic test_countdown();
    int exp_cnt, exp_state;
    cyc(1, 0, 0, 0);
`ifndef FRAME_SYNC_EN
    n_checks++; if (bus.state !== 3'd2 || bus.cnt0 !== 4'd3)
      begin n_fail++; $display("FAIL countdown_start got st %0d cnt %0d exp st 2 cnt 3", bus.state, bus.cnt0); end
`endif
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 0, 0, 0);
      n_checks++; if (bus.ball_en !== (k == 12))
        begin n_fail++; $display("FAIL countdown_ball_en k=%0d got %0b exp %0b", k, bus.ball_en, (k == 12)); end
      exp_state = (k == 12) ? 3 : 2;
      exp_cnt   = (k == 12) ? 0 : 3 - k / 4;
`ifndef FRAME_SYNC_EN
      n_checks++; if (bus.state !== 3'(exp_state) || bus.cnt0 !== 4'(exp_cnt))
        begin n_fail++; $display("FAIL countdown_k%0d got st %0d cnt %0d exp st %0d cnt %0d", k, bus.state, bus.cnt0, exp_state, exp_cnt); end
`endif
    end
  endtask

  task automatic test_point_reserve();
    cyc(0, 0, 0, 1);
    n_checks++; if (bus.serve_dir !== 1'b0 || bus.ball_en !== 1'b0)
      begin n_fail++; $display("FAIL point1_flags got dir %0b ball %0b exp dir 0 ball 0", bus.serve_dir, bus.ball_en); end
`ifndef FRAME_SYNC_EN
    n_checks++; if (bus.score1 !== 4'd1 || bus.state !== 3'd2 || bus.cnt0 !== 4'd3)
      begin n_fail++; $display("FAIL point1_display got s1 %0d st %0d cnt %0d exp 1 2 3", bus.score1, bus.state, bus.cnt0); end
`endif
    run_idle(12);
    cyc(0, 0, 0, 1);
    n_checks++; if (bus.winner !== 1'b1) begin n_fail++; $display("FAIL win1_winner got %0b exp 1", bus.winner); end
`ifndef FRAME_SYNC_EN
    n_checks++; if (bus.state !== 3'd4 || bus.score1 !== 4'd2)
      begin n_fail++; $display("FAIL win1_display got st %0d s1 %0d exp 4 2", bus.state, bus.score1); end
`endif
    cyc(1, 0, 0, 0);
`ifndef FRAME_SYNC_EN
    n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL finish_start got %0d exp 0", bus.state); end
`endif
    cyc(0, 0, 0, 0);
`ifndef FRAME_SYNC_EN
    n_checks++; if (bus.state !== 3'd1 || bus.score0 !== 4'd0 || bus.score1 !== 4'd0)
      begin n_fail++; $display("FAIL restart_clear got st %0d %0d-%0d exp 1 0-0", bus.state, bus.score0, bus.score1); end
`endif
    n_checks++; if (bus.winner !== 1'b0) begin n_fail++; $display("FAIL restart_winner got %0b exp 0", bus.winner); end
  endtask

  task automatic test_simultaneous();
    cyc(1, 0, 0, 0); run_idle(12);
    cyc(0, 0, 1, 0);
    n_checks++; if (bus.serve_dir !== 1'b1) begin n_fail++; $display("FAIL point0_dir got %0b exp 1", bus.serve_dir); end
    run_idle(12);
    cyc(0, 0, 0, 1); run_idle(12);
    cyc(1, 0, 0, 0);
    n_checks++; if (bus.ball_en !== 1'b1) begin n_fail++; $display("FAIL start_in_play got ball %0b exp 1", bus.ball_en); end
    cyc(0, 0, 1, 1);
    n_checks++; if (bus.winner !== 1'b0 || bus.ball_en !== 1'b0 || bus.serve_dir !== 1'b0)
      begin n_fail++; $display("FAIL double_flags got win %0b ball %0b dir %0b exp 0 0 0", bus.winner, bus.ball_en, bus.serve_dir); end
`ifndef FRAME_SYNC_EN
    n_checks++; if (bus.state !== 3'd4 || bus.score0 !== 4'd2 || bus.score1 !== 4'd2)
      begin n_fail++; $display("FAIL double_display got st %0d %0d-%0d exp 4 2-2", bus.state, bus.score0, bus.score1); end
`endif
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
  endtask

  task automatic test_abort();
    cyc(1, 0, 0, 0); run_idle(12);
    cyc(0, 0, 1, 0); run_idle(12);
    cyc(0, 1, 1, 0);
    n_checks++; if (bus.ball_en !== 1'b0) begin n_fail++; $display("FAIL abort_ball got %0b exp 0", bus.ball_en); end
`ifndef FRAME_SYNC_EN
    n_checks++; if (bus.state !== 3'd0 || bus.score0 !== 4'd1)
      begin n_fail++; $display("FAIL abort_prio got st %0d s0 %0d exp 0 1", bus.state, bus.score0); end
`endif
    cyc(0, 0, 0, 0);
    n_checks++; if (bus.serve_dir !== 1'b0) begin n_fail++; $display("FAIL abort_dir got %0b exp 0", bus.serve_dir); end
`ifndef FRAME_SYNC_EN
    n_checks++; if (bus.state !== 3'd1 || bus.score0 !== 4'd0 || bus.score1 !== 4'd0)
      begin n_fail++; $display("FAIL abort_brst got st %0d %0d-%0d exp 1 0-0", bus.state, bus.score0, bus.score1); end
`endif
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 0, 0); run_idle(5);
    @(negedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if ({bus.state, bus.score0, bus.score1, bus.cnt0} !== 15'd0)
      begin n_fail++; $display("FAIL async_display got st %0d %0d-%0d cnt %0d exp all 0", bus.state, bus.score0, bus.score1, bus.cnt0); end
    n_checks++; if ({bus.ball_en, bus.serve_dir, bus.winner} !== 3'b000)
      begin n_fail++; $display("FAIL async_flags got %b exp 000", {bus.ball_en, bus.serve_dir, bus.winner}); end
    @(negedge clk);
    bus.vsync = 1'b1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    n_checks++; if (bus.state !== 3'(d_state)) begin n_fail++; $display("FAIL async_release got %0d exp %0d", bus.state, d_state); end
  endtask

  task automatic test_random();
    bit st, ab, p0, p1;
    for (int i = 0; i < 900; i++) begin
      st = ($urandom % 6) == 0;
      ab = ($urandom % 90) == 0;
      p0 = ($urandom % 4) == 0;
      p1 = ($urandom % 4) == 0;
      cyc(st, ab, p0, p1);
      n_checks++; if (bus.state !== 3'(d_state))  begin n_fail++; $display("FAIL rnd_state i=%0d got %0d exp %0d", i, bus.state, d_state); end
      n_checks++; if (bus.score0 !== 4'(d_s0))    begin n_fail++; $display("FAIL rnd_score0 i=%0d got %0d exp %0d", i, bus.score0, d_s0); end
      n_checks++; if (bus.score1 !== 4'(d_s1))    begin n_fail++; $display("FAIL rnd_score1 i=%0d got %0d exp %0d", i, bus.score1, d_s1); end
      n_checks++; if (bus.cnt0 !== 4'(d_cnt))     begin n_fail++; $display("FAIL rnd_cnt0 i=%0d got %0d exp %0d", i, bus.cnt0, d_cnt); end
      n_checks++; if (bus.ball_en !== (m_state == 3)) begin n_fail++; $display("FAIL rnd_ball_en i=%0d got %0b exp %0b", i, bus.ball_en, (m_state == 3)); end
      n_checks++; if (bus.serve_dir !== m_dir[0]) begin n_fail++; $display("FAIL rnd_serve_dir i=%0d got %0b exp %0b", i, bus.serve_dir, m_dir[0]); end
      n_checks++; if (bus.winner !== m_winner())  begin n_fail++; $display("FAIL rnd_winner i=%0d got %0b exp %0b", i, bus.winner, m_winner()); end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_point_reserve();
    test_simultaneous();
    test_abort();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
